knap_search_ctrl: RTL and testbench



---
 rtl/knap_search_ctrl.sv | 135 +++++++++++++
 tb/tb_knap_search_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/knap_search_ctrl.sv
// Exhaustive-search sequencer: sweeps every item-selection vector into an external
// combinational knapsack checker and keeps the best valid selection and the valid count.
module knap_search_ctrl #(
  parameter int N_ITEMS = 6,
  parameter int VW      = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic               hold,
  output logic [N_ITEMS-1:0] cand,
  input  logic               chk_valid,
  input  logic [VW-1:0]      chk_value,
  output logic               busy,
  output logic               done,
  output logic               found,
  output logic [N_ITEMS-1:0] best_sel,
  output logic [VW-1:0]      best_value,
  output logic [N_ITEMS:0]   num_valid
);

  typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DRAIN, S_DONE} state_t;

  state_t               r_state;
  logic [N_ITEMS-1:0]   r_cand;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_s1_vld;
  logic                 r_s1_valid;
  logic [VW-1:0]        r_s1_value;
  logic [N_ITEMS-1:0]   r_s1_sel;
  logic                 r_found;
  logic [N_ITEMS-1:0]   r_best_sel;
  logic [VW-1:0]        r_best_value;
  logic [N_ITEMS:0]     r_num_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cand       <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_s1_vld     <= 1'b0;
      r_s1_valid   <= 1'b0;
      r_s1_value   <= '0;
      r_s1_sel     <= '0;
      r_found      <= 1'b0;
      r_best_sel   <= '0;
      r_best_value <= '0;
      r_num_valid  <= '0;
    end else begin
      r_done <= 1'b0;

      // Strictly-greater compare keeps the lower-index selection on a tie.
      if (r_s1_vld && r_s1_valid) begin
        r_num_valid <= r_num_valid + (N_ITEMS+1)'(1);
        if (!r_found || (r_s1_value > r_best_value)) begin
          r_best_sel   <= r_s1_sel;
          r_best_value <= r_s1_value;
          r_found      <= 1'b1;
        end
      end

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state      <= S_SWEEP;
            r_cand       <= '0;
            r_busy       <= 1'b1;
            r_found      <= 1'b0;
            r_best_sel   <= '0;
            r_best_value <= '0;
            r_num_valid  <= '0;
          end
        end

        S_SWEEP: begin
          if (abort) begin
            r_state      <= S_IDLE;
            r_busy       <= 1'b0;
            r_cand       <= '0;
            r_s1_vld     <= 1'b0;
            r_found      <= 1'b0;
            r_best_sel   <= '0;
            r_best_value <= '0;
            r_num_valid  <= '0;
          end else if (hold) begin
            r_s1_vld <= 1'b0;
          end else begin
            r_s1_vld   <= 1'b1;
            r_s1_valid <= chk_valid;
            r_s1_value <= chk_value;
            r_s1_sel   <= r_cand;
            if (&r_cand) begin
              r_state <= S_DRAIN;
            end else begin
              r_cand <= r_cand + N_ITEMS'(1);
            end
          end
        end

        S_DRAIN: begin
          r_s1_vld <= 1'b0;
          r_cand   <= '0;
          r_busy   <= 1'b0;
          if (abort) begin
            r_state      <= S_IDLE;
            r_found      <= 1'b0;
            r_best_sel   <= '0;
            r_best_value <= '0;
            r_num_valid  <= '0;
          end else begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_cand  <= '0;
        end
      endcase
    end
  end

  assign cand       = r_cand;
  assign busy       = r_busy;
  assign done       = r_done;
  assign found      = r_found;
  assign best_sel   = r_best_sel;
  assign best_value = r_best_value;
  assign num_valid  = r_num_valid;

endmodule

// File: tb/tb_knap_search_ctrl.sv
// Bench for knap_search_ctrl: a behavioural checker model drives the DUT, and a
// whole-space reference search predicts found/best/count for each sweep.
module tb_knap_search_ctrl;

  localparam int N  = 6;
  localparam int VW = 6;
  localparam int IV [6] = '{4, 2, 2, 1, 10, 20};
  localparam int IW [6] = '{12, 1, 2, 1, 4, 1};
  localparam int IL [6] = '{10, 2, 1, 4, 3, 12};

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic         hold = 1'b0;
  logic [N-1:0] cand;
  logic         chk_valid;
  logic [VW-1:0] chk_value;
  logic         busy, done, found;
  logic [N-1:0] best_sel;
  logic [VW-1:0] best_value;
  logic [N:0]   num_valid;

  int           mode = 0;
  logic [63:0]  rnd_vld = '0;
  logic [383:0] rnd_val = '0;

  int tests = 0;
  int fails = 0;

  logic         e_found;
  logic [N-1:0] e_sel;
  logic [VW-1:0] e_val;
  logic [N:0]   e_num;

  knap_search_ctrl #(.N_ITEMS(N), .VW(VW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .hold(hold),
    .cand(cand), .chk_valid(chk_valid), .chk_value(chk_value),
    .busy(busy), .done(done), .found(found), .best_sel(best_sel),
    .best_value(best_value), .num_valid(num_valid)
  );

  always #5 clk = ~clk;

  // Checker environment: 0 knapsack, 1 value=cand, 2 const 5, 3 never valid, 4 random table.
  function automatic logic [VW:0] chk_fn(input int m, input logic [N-1:0] s,
                                         input logic [63:0] rv, input logic [383:0] rval);
    int v, w, l;
    v = 0; w = 0; l = 0;
    case (m)
      0: begin
        for (int i = 0; i < 6; i++) if (s[i]) begin v += IV[i]; w += IW[i]; l += IL[i]; end
        return {(v >= 15 && w <= 16 && l <= 10), VW'(v)};
      end
      1: return {1'b1, VW'(s)};
      2: return {1'b1, VW'(5)};
      3: return {1'b0, VW'(0)};
      default: return {rv[s], rval[int'(s)*6 +: 6]};
    endcase
  endfunction

  always_comb {chk_valid, chk_value} = chk_fn(mode, cand, rnd_vld, rnd_val);

  task automatic compute_model();
    logic [VW:0] r;
    e_found = 1'b0; e_sel = '0; e_val = '0; e_num = '0;
    for (int s = 0; s < 64; s++) begin
      r = chk_fn(mode, N'(s), rnd_vld, rnd_val);
      if (r[VW]) begin
        e_num = e_num + 1;
        if (!e_found || r[VW-1:0] > e_val) begin
          e_found = 1'b1; e_sel = N'(s); e_val = r[VW-1:0];
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_results(input string tag);
    chk({tag, "_found"}, 64'(found), 64'(e_found));
    chk({tag, "_sel"},   64'(best_sel), 64'(e_sel));
    chk({tag, "_val"},   64'(best_value), 64'(e_val));
    chk({tag, "_num"},   64'(num_valid), 64'(e_num));
  endtask

  // Starts a sweep from IDLE and returns #1 after the edge that raised done.
  task automatic do_sweep(input int hold_cand, input int hold_len, input int restart_at,
                          output int edges);
    int held;
    logic got;
    logic was_hold, was_start;
    held = 0; got = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    edges = 0;
    chk("busy_after_e0", 64'(busy), 64'd1);
    for (int c = 0; c < 400 && !got; c++) begin
      was_hold  = (int'(cand) == hold_cand) && (held < hold_len);
      was_start = (int'(cand) == restart_at);
      if (was_hold) held++;
      hold  = was_hold;
      start = was_start;
      @(posedge clk); #1;
      edges++;
      if (was_hold)  chk("hold_cand", 64'(cand), 64'(hold_cand));
      if (was_start) chk("restart_ignored", 64'(cand), 64'(restart_at + 1));
      hold = 1'b0; start = 1'b0;
      if (done) got = 1'b1;
    end
    if (!got) chk("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic after_done(input string tag);
    @(posedge clk); #1;
    chk({tag, "_done_width"}, 64'(done), 64'd0);
    chk({tag, "_idle"}, 64'(busy), 64'd0);
    chk({tag, "_held_num"}, 64'(num_valid), 64'(e_num));
  endtask

  initial begin
    int edges;
    logic [N-1:0] sv_sel;
    logic [VW-1:0] sv_val;
    logic [N:0] sv_num;
    logic seen_done;

    #12 rst = 1'b0;
    #1;
    chk("rst_cand", 64'(cand), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_found", 64'(found), 64'd0);
    chk("rst_best_sel", 64'(best_sel), 64'd0);
    chk("rst_best_val", 64'(best_value), 64'd0);
    chk("rst_num", 64'(num_valid), 64'd0);
    @(posedge clk); #1;

    // Knapsack checker, plus a start in the DONE cycle that must be ignored.
    mode = 0; compute_model();
    do_sweep(-1, 0, -1, edges);
    chk("knap_latency", 64'(edges), 64'd65);
    check_results("knap");
    chk("knap_sel_lit", 64'(best_sel), 64'h1E);
    chk("knap_val_lit", 64'(best_value), 64'd15);
    chk("knap_num_lit", 64'(num_valid), 64'd1);
    start = 1'b1;
    after_done("knap");
    start = 1'b0;
    $display("[TB] sweep knap edges=%0d sel=%0h val=%0d num=%0d", edges, best_sel, best_value, num_valid);

    mode = 1; compute_model();
    do_sweep(-1, 0, -1, edges);
    check_results("ident");
    chk("ident_sel_lit", 64'(best_sel), 64'd63);
    chk("ident_num_lit", 64'(num_valid), 64'd64);
    after_done("ident");
    $display("[TB] sweep ident edges=%0d sel=%0h val=%0d num=%0d", edges, best_sel, best_value, num_valid);

    // Constant value: tie keeps selection 0; also a start pulse mid-sweep.
    mode = 2; compute_model();
    do_sweep(-1, 0, 10, edges);
    chk("const_latency", 64'(edges), 64'd65);
    check_results("const");
    chk("const_sel_lit", 64'(best_sel), 64'd0);
    after_done("const");
    $display("[TB] sweep const edges=%0d sel=%0h val=%0d num=%0d", edges, best_sel, best_value, num_valid);

    mode = 3; compute_model();
    do_sweep(-1, 0, -1, edges);
    check_results("none");
    after_done("none");
    $display("[TB] sweep none edges=%0d found=%0d num=%0d", edges, found, num_valid);

    mode = 4;
    rnd_vld = {$urandom, $urandom};
    for (int i = 0; i < 64; i++) rnd_val[i*6 +: 6] = 6'($urandom);
    compute_model();
    do_sweep(-1, 0, -1, edges);
    check_results("rand");
    sv_sel = best_sel; sv_val = best_value; sv_num = num_valid;
    after_done("rand");
    $display("[TB] sweep rand edges=%0d sel=%0h val=%0d num=%0d", edges, best_sel, best_value, num_valid);

    do_sweep(20, 10, -1, edges);
    chk("hold_latency", 64'(edges), 64'd75);
    check_results("hold");
    chk("hold_same_sel", 64'(best_sel), 64'(sv_sel));
    chk("hold_same_val", 64'(best_value), 64'(sv_val));
    chk("hold_same_num", 64'(num_valid), 64'(sv_num));
    after_done("hold");
    $display("[TB] sweep hold edges=%0d sel=%0h val=%0d num=%0d", edges, best_sel, best_value, num_valid);

    // Abort at cand=30.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 100 && cand != 6'd30; c++) begin
      @(posedge clk); #1;
    end
    chk("abort_reach30", 64'(cand), 64'd30);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_cand", 64'(cand), 64'd0);
    chk("abort_num", 64'(num_valid), 64'd0);
    chk("abort_found", 64'(found), 64'd0);
    seen_done = done;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      seen_done |= done | busy;
    end
    chk("abort_no_done", 64'(seen_done), 64'd0);
    $display("[TB] abort at cand=30 busy=%0d num=%0d", busy, num_valid);
    do_sweep(-1, 0, -1, edges);
    chk("post_abort_latency", 64'(edges), 64'd65);
    check_results("post_abort");
    after_done("post_abort");
    $display("[TB] sweep post_abort edges=%0d num=%0d", edges, num_valid);

    // Asynchronous reset mid-cycle at cand=40.
    mode = 1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 100 && cand != 6'd40; c++) begin
      @(posedge clk); #1;
    end
    chk("rst_reach40", 64'(cand), 64'd40);
    chk("rst_pre_found", 64'(found), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_cand", 64'(cand), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_found", 64'(found), 64'd0);
    chk("arst_sel", 64'(best_sel), 64'd0);
    chk("arst_val", 64'(best_value), 64'd0);
    chk("arst_num", 64'(num_valid), 64'd0);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("arst_idle_busy", 64'(busy), 64'd0);
    chk("arst_idle_done", 64'(done), 64'd0);
    $display("[TB] reset at cand=40 cand=%0d busy=%0d", cand, busy);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
